// File: rtl/if_fetch_ctrl.sv
// IF-stage AXI4 read master: turns PC fetch requests into single-beat reads,
// buffers the instruction for IF/ID, and drains stale beats after a redirect.
// Optional feature macro: FETCH_ERR_EN (sticky RRESP error, NOP substitution).
module if_fetch_ctrl #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [3:0]  MASTER_ID = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              redirect,
    input  logic              pipe_stall,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              fetch_stall,
    output logic              fetch_err,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] aligned_addr;
    logic              kill_now;
    logic              bad_resp;

    // RID is not checked (single outstanding transaction); byte offset is dropped.
    logic unused_inputs;
    assign unused_inputs = ^{RID, fetch_addr[1:0], RRESP};

    assign aligned_addr = {fetch_addr[ADDR_W-1:2], 2'b00};
    // A redirect arriving with the final beat must already drop that beat.
    assign kill_now     = kill_q | redirect;
    assign bad_resp     = (RRESP != 2'b00);

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        araddr_d = araddr_q;
        inst_d   = inst_q;
        case (state_q)
            IDLE: begin
                if (fetch_req && !redirect) begin
                    state_d  = AR;
                    araddr_d = aligned_addr;
                end
            end
            AR: begin
                if (redirect) begin
                    kill_d = 1'b1;
                end
                if (ARREADY) begin
                    state_d = R;
                end
            end
            R: begin
                if (redirect) begin
                    kill_d = 1'b1;
                end
                if (RVALID && RLAST) begin
                    if (kill_now) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
`ifdef FETCH_ERR_EN
                        inst_d  = bad_resp ? NOP : RDATA;
`else
                        inst_d  = RDATA;
`endif
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (redirect) begin
                    state_d = IDLE;
                end else if (!pipe_stall) begin
                    if (fetch_req) begin
                        state_d  = AR;
                        araddr_d = aligned_addr;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            kill_q   <= 1'b0;
            araddr_q <= '0;
            inst_q   <= NOP;
        end else begin
            state_q  <= state_d;
            kill_q   <= kill_d;
            araddr_q <= araddr_d;
            inst_q   <= inst_d;
        end
    end

`ifdef FETCH_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == R && RVALID && !kill_now && bad_resp) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = bad_resp;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        fetch_stall = 1'b1;
        if (!rst) begin
            case (state_q)
                IDLE:    fetch_stall = fetch_req;
                DONE:    fetch_stall = pipe_stall;
                default: fetch_stall = 1'b1;
            endcase
        end
    end

    assign inst_out   = inst_q;
    assign inst_valid = (state_q == DONE);
    assign ARVALID    = (state_q == AR);
    assign RREADY     = (state_q == R);
    assign ARADDR     = araddr_q;
    assign ARID       = MASTER_ID;
    assign ARLEN      = 4'd0;
    assign ARSIZE     = 3'b010;
    assign ARBURST    = 2'b01;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model of the fetch unit and a simple AXI slave.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        redirect;
    logic        pipe_stall;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        fetch_stall;
    logic        fetch_err;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .MASTER_ID(4'h0)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .redirect(redirect), .pipe_stall(pipe_stall),
        .inst_out(inst_out), .inst_valid(inst_valid),
        .fetch_stall(fetch_stall), .fetch_err(fetch_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: which bus phase is outstanding, whether it is stale, and the buffer.
    bit          m_addr_pending;
    bit          m_data_pending;
    bit          m_stale;
    bit          m_have;
    bit          m_err;
    logic [31:0] m_addr;
    logic [31:0] m_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr_pending = 0;
        m_data_pending = 0;
        m_stale        = 0;
        m_have         = 0;
        m_err          = 0;
        m_addr         = 32'h0;
        m_inst         = 32'h0000_0013;
    endtask

    task automatic compare_all();
        bit exp_stall;
        if (rst) exp_stall = 1;
        else if (m_addr_pending || m_data_pending) exp_stall = 1;
        else if (m_have) exp_stall = pipe_stall;
        else exp_stall = fetch_req;
        chk("ARVALID", 32'(ARVALID), 32'(m_addr_pending));
        chk("RREADY", 32'(RREADY), 32'(m_data_pending));
        chk("inst_valid", 32'(inst_valid), 32'(m_have));
        chk("fetch_stall", 32'(fetch_stall), 32'(exp_stall));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        if (m_addr_pending) chk("ARADDR", ARADDR, m_addr);
        if (m_have) chk("inst_out", inst_out, m_inst);
    endtask

    task automatic model_step();
        if (m_addr_pending) begin
            if (redirect) m_stale = 1;
            if (ARREADY) begin
                m_addr_pending = 0;
                m_data_pending = 1;
            end
        end else if (m_data_pending) begin
            if (redirect) m_stale = 1;
            if (RVALID) begin
`ifdef FETCH_ERR_EN
                if (!m_stale && RRESP != 2'b00) m_err = 1;
`endif
                if (RLAST) begin
                    m_data_pending = 0;
                    if (m_stale) begin
                        m_stale = 0;
                    end else begin
                        m_have = 1;
`ifdef FETCH_ERR_EN
                        m_inst = (RRESP != 2'b00) ? 32'h0000_0013 : RDATA;
`else
                        m_inst = RDATA;
`endif
                    end
                end
            end
        end else if (m_have) begin
            if (redirect) begin
                m_have = 0;
            end else if (!pipe_stall) begin
                m_have = 0;
                if (fetch_req) begin
                    m_addr_pending = 1;
                    m_addr = {fetch_addr[31:2], 2'b00};
                end
            end
        end else if (fetch_req && !redirect) begin
            m_addr_pending = 1;
            m_addr = {fetch_addr[31:2], 2'b00};
        end
    endtask

    task automatic tick(input bit fr, input logic [31:0] fa, input bit rd, input bit ps,
                        input bit arr, input bit rv, input logic [31:0] rdat,
                        input logic [1:0] rr, input bit rl);
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = fa;
        redirect   = rd;
        pipe_stall = ps;
        ARREADY    = arr;
        RVALID     = rv;
        RDATA      = rdat;
        RRESP      = rr;
        RLAST      = rl;
        RID        = 4'h0;
        #1;
        compare_all();
        model_step();
    endtask

    logic [31:0] exp_err_inst;
    logic [31:0] exp_err_flag;

    initial begin
`ifdef FETCH_ERR_EN
        exp_err_inst = 32'h0000_0013;
        exp_err_flag = 32'h1;
`else
        exp_err_inst = 32'h1234_5678;
        exp_err_flag = 32'h0;
`endif
        rst = 1; fetch_req = 0; fetch_addr = 0; redirect = 0; pipe_stall = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
        model_reset();
        #3;
        chk("rst ARVALID", 32'(ARVALID), 32'h0);
        chk("rst RREADY", 32'(RREADY), 32'h0);
        chk("rst ARADDR", ARADDR, 32'h0);
        chk("rst inst_valid", 32'(inst_valid), 32'h0);
        chk("rst inst_out", inst_out, 32'h0000_0013);
        chk("rst fetch_stall", 32'(fetch_stall), 32'h1);
        chk("rst fetch_err", 32'(fetch_err), 32'h0);
        chk("ARID", 32'(ARID), 32'h0);
        chk("ARLEN", 32'(ARLEN), 32'h0);
        chk("ARSIZE", 32'(ARSIZE), 32'h2);
        chk("ARBURST", 32'(ARBURST), 32'h1);
        @(negedge clk);
        rst = 0;

        // Basic fetch with the documented cycle latency.
        tick(1, 32'h0000_0104, 0, 0, 1, 0, 0, 0, 0);
        chk("basic c0 stall", 32'(fetch_stall), 32'h1);
        tick(0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
        chk("basic c1 ARVALID", 32'(ARVALID), 32'h1);
        chk("basic c1 ARADDR", ARADDR, 32'h0000_0104);
        tick(0, 32'h0, 0, 0, 0, 1, 32'h00A0_0093, 2'b00, 1);
        chk("basic c2 RREADY", 32'(RREADY), 32'h1);
        $display("txn basic fetch addr=00000104 data=%h", inst_out);

        // Pipe stall in DONE for 4 cycles, then back-to-back request.
        for (int i = 0; i < 4; i++) begin
            tick(1, 32'h0000_0109, 0, 1, 0, 0, 0, 0, 0);
            chk("hold inst_valid", 32'(inst_valid), 32'h1);
            chk("hold inst_out", inst_out, 32'h00A0_0093);
            chk("hold no ARVALID", 32'(ARVALID), 32'h0);
        end
        tick(1, 32'h0000_0109, 0, 0, 0, 0, 0, 0, 0);
        chk("release stall", 32'(fetch_stall), 32'h0);
        $display("txn pipe stall released inst=%h", inst_out);

        // Slave backpressure for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
            chk("bp ARVALID", 32'(ARVALID), 32'h1);
            chk("bp ARADDR", ARADDR, 32'h0000_0108);
            chk("bp stall", 32'(fetch_stall), 32'h1);
        end
        tick(0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
        $display("txn backpressure handshake addr=%h", ARADDR);

        // Redirect while waiting for data; stale beat is drained.
        tick(0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        chk("redir RREADY", 32'(RREADY), 32'h1);
        tick(0, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF, 2'b00, 1);
        chk("drain RREADY", 32'(RREADY), 32'h1);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain inst_valid", 32'(inst_valid), 32'h0);
        chk("drain idle stall", 32'(fetch_stall), 32'h0);
        tick(1, 32'h0000_0200, 0, 0, 1, 0, 0, 0, 0);
        tick(0, 32'h0, 0, 0, 1, 0, 0, 0, 0);
        chk("post redir ARVALID", 32'(ARVALID), 32'h1);
        chk("post redir ARADDR", ARADDR, 32'h0000_0200);
        $display("txn redirect drained, new AR addr=%h", ARADDR);

        // Error response.
        tick(0, 32'h0, 0, 0, 0, 1, 32'h1234_5678, 2'b10, 1);
        tick(0, 32'h0, 0, 1, 0, 0, 0, 0, 0);
        chk("err inst_valid", 32'(inst_valid), 32'h1);
        chk("err inst_out", inst_out, exp_err_inst);
        chk("err flag", 32'(fetch_err), exp_err_flag);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        chk("err sticky", 32'(fetch_err), exp_err_flag);
        $display("txn error response inst=%h err=%0d", inst_out, fetch_err);

        // Asynchronous reset mid-cycle while in AR.
        tick(1, 32'h0000_0300, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre-rst ARVALID", 32'(ARVALID), 32'h1);
        #1 rst = 1;
        #1;
        chk("arst ARVALID", 32'(ARVALID), 32'h0);
        chk("arst inst_valid", 32'(inst_valid), 32'h0);
        chk("arst fetch_stall", 32'(fetch_stall), 32'h1);
        chk("arst fetch_err", 32'(fetch_err), 32'h0);
        chk("arst ARADDR", ARADDR, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        $display("txn async reset in AR");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit fr, rd, ps, arr, rv, rl;
            logic [1:0] rr;
            fr  = ($urandom % 4) != 0;
            rd  = ($urandom % 8) == 0;
            ps  = ($urandom % 3) == 0;
            arr = ($urandom % 2) == 0;
            rv  = m_data_pending && (($urandom % 3) != 0);
            rl  = ($urandom % 4) != 0;
            rr  = (($urandom % 6) == 0) ? 2'b10 : 2'b00;
            tick(fr, $urandom, rd, ps, arr, rv, $urandom, rr, rl);
            if (m_have && !fetch_stall)
                $display("txn rand %0d inst=%h", i, inst_out);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
